// File: rtl/conv1_mac4.sv
// conv1_mac4 - four-window 5x5 convolution engine for the conv1 layer (convPool1 stage).
//
// A 6x6 tile and a 5x5 kernel are captured together. The four 5x5 windows at offsets
// (0,0),(0,1),(1,0),(1,1) are then accumulated one kernel tap per cycle on four parallel
// MACs. The bias is added, the sum is shifted and saturated to 16 bits, and the result is
// held for the controller's reluPool.
//
// Handshake (level based, no ready):
//   A computation starts when imVld & iwVld are both sampled high in IDLE. The tile, kernel
//   and bias are copied on that edge, so later changes to them are ignored. convResVld then
//   stays high with stable results until the controller drops imVld. Because imVld must fall
//   before the next capture, one tile always yields exactly one result. Dropping imVld while
//   the MACs are running aborts the tile without producing a result.
//
// Ports:
//   clk                     clock, rising edge
//   rst                     asynchronous, active-low reset
//   iwVld                   kernel/bias valid (level)
//   imVld                   tile valid (level)
//   ib     [DATA_SIZE]      bias, signed
//   im     [36*DATA_SIZE]   6x6 tile, unsigned, pixel (r,c) at the MSB end for (0,0)
//   iw     [25*DATA_SIZE]   5x5 kernel, signed, tap (kr,kc) at the MSB end for (0,0)
//   convResVld              conv1_num1..4 valid (level)
//   conv1_num1..4 [16]      signed results for window offsets (0,0),(0,1),(1,0),(1,1)
//   dbgState [2]            current FSM state, for observation only

module conv1_mac4 #(
    parameter int DATA_SIZE  = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int BIAS_SHIFT = 0,
    parameter int OUT_SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     iwVld,
    input  logic                     imVld,
    input  logic [DATA_SIZE-1:0]     ib,
    input  logic [36*DATA_SIZE-1:0]  im,
    input  logic [25*DATA_SIZE-1:0]  iw,
    output logic                     convResVld,
    output logic [15:0]              conv1_num1,
    output logic [15:0]              conv1_num2,
    output logic [15:0]              conv1_num3,
    output logic [15:0]              conv1_num4,
    output logic [1:0]               dbgState
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2,
        HOLD = 2'd3
    } state_t;

    // Unsigned pixel (zero-extended) times signed tap needs 2*DATA_SIZE+1 bits.
    localparam int PW = 2 * DATA_SIZE + 1;
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(-32768);

    state_t state, nextState;

    logic [36*DATA_SIZE-1:0]     imReg;
    logic [25*DATA_SIZE-1:0]     iwReg;
    logic [DATA_SIZE-1:0]        ibReg;
    logic [4:0]                  tap;
    logic [2:0]                  kr, kc;
    logic signed [ACC_WIDTH-1:0] acc [4];
    logic [15:0]                 numReg [4];

    logic                        startTile;
    logic [DATA_SIZE-1:0]        wTap;
    logic [DATA_SIZE-1:0]        pix [4];
    logic signed [PW-1:0]        prod [4];
    logic signed [ACC_WIDTH-1:0] biasExt;
    logic signed [ACC_WIDTH-1:0] shifted [4];
    logic [15:0]                 yVal [4];
    int                          pixIdx;

    assign startTile = imVld && iwVld;
    assign dbgState  = state;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (startTile) nextState = MAC;
            MAC: begin
                if (!imVld)             nextState = IDLE;
                else if (tap == 5'd24)  nextState = OUT;
            end
            OUT:  nextState = HOLD;
            HOLD: if (!imVld) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // ---------------- MAC datapath ----------------
    // All four windows share the current kernel tap; only the pixel offset differs.
    always_comb begin
        pixIdx = 0;
        wTap   = iwReg[25*DATA_SIZE-1 - DATA_SIZE*(5*int'(kr) + int'(kc)) -: DATA_SIZE];
        for (int k = 0; k < 4; k++) begin
            pixIdx  = 6 * (int'(kr) + k / 2) + int'(kc) + k % 2;
            pix[k]  = imReg[36*DATA_SIZE-1 - DATA_SIZE*pixIdx -: DATA_SIZE];
            prod[k] = PW'(pix[k]) * PW'($signed(wTap));
        end
    end

    // Bias add, output shift and 16-bit saturation.
    always_comb begin
        biasExt = ACC_WIDTH'($signed(ibReg)) <<< BIAS_SHIFT;
        for (int k = 0; k < 4; k++) begin
            shifted[k] = (acc[k] + biasExt) >>> OUT_SHIFT;
            if (shifted[k] > SAT_MAX)      yVal[k] = 16'h7FFF;
            else if (shifted[k] < SAT_MIN) yVal[k] = 16'h8000;
            else                           yVal[k] = shifted[k][15:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imReg      <= '0;
            iwReg      <= '0;
            ibReg      <= '0;
            tap        <= '0;
            kr         <= '0;
            kc         <= '0;
            convResVld <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                acc[k]    <= '0;
                numReg[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (startTile) begin
                        imReg <= im;
                        iwReg <= iw;
                        ibReg <= ib;
                        tap   <= '0;
                        kr    <= '0;
                        kc    <= '0;
                        for (int k = 0; k < 4; k++) acc[k] <= '0;
                    end
                end
                MAC: begin
                    if (imVld) begin
                        for (int k = 0; k < 4; k++) acc[k] <= acc[k] + ACC_WIDTH'(prod[k]);
                        tap <= tap + 5'd1;
                        if (kc == 3'd4) begin
                            kc <= '0;
                            kr <= kr + 3'd1;
                        end else begin
                            kc <= kc + 3'd1;
                        end
                    end
                end
                OUT: begin
                    for (int k = 0; k < 4; k++) numReg[k] <= yVal[k];
                    convResVld <= 1'b1;
                end
                HOLD: begin
                    if (!imVld) convResVld <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign conv1_num1 = numReg[0];
    assign conv1_num2 = numReg[1];
    assign conv1_num3 = numReg[2];
    assign conv1_num4 = numReg[3];

endmodule
